// File: rtl/job_host_pkg.sv
// Shared types and constants for the job_host sequencer and its result FIFO.
// A result record packs {y, s, b, regime, timeout} with timeout in the LSB.
package job_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_ACT,
        RUN,
        CAPTURE
    } state_e;

    localparam int RES_W       = 8 + 3 + 1 + 2 + 1;
    localparam int RES_TMO_O   = 0;
    localparam int RES_REG_O   = 1;
    localparam int RES_B_O     = 3;
    localparam int RES_S_O     = 4;
    localparam int RES_Y_O     = 7;
    localparam int TIMEOUT_DEF = 255;

    function automatic logic [RES_W-1:0] pack_res(
        input logic [7:0] y,
        input logic [2:0] s,
        input logic       b,
        input logic [1:0] regime,
        input logic       tmo
    );
        return {y, s, b, regime, tmo};
    endfunction

endpackage

// File: rtl/job_host_fifo.sv
// Show-ahead synchronous result FIFO: head entry is presented straight from storage.
// Pointers wrap naturally because DEPTH is a power of two; pop on empty is ignored.
module job_host_fifo
    import job_host_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [RES_W-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [RES_W-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [RES_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && (count_q != FULL_CNT);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/job_host.sv
// Initiator-side sequencer for `main`: launches one job at a time, watches the
// active handshake with an abort timer, and queues captured results.
module job_host
    import job_host_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_x_i,
    input  logic [1:0] cmd_on_i,
    output logic [7:0] x_o,
    output logic [1:0] on_o,
    output logic       start_o,
    input  logic       active_i,
    input  logic [7:0] y_i,
    input  logic [2:0] s_i,
    input  logic       b_i,
    input  logic [1:0] regime_i,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic [7:0] res_y_o,
    output logic [2:0] res_s_o,
    output logic       res_b_o,
    output logic [1:0] res_regime_o,
    output logic       res_timeout_o,
    output logic       busy_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [7:0]    TMO_LAST = 8'(TIMEOUT - 1);

    state_e           state_q;
    logic [7:0]       x_q;
    logic [1:0]       on_q;
    logic             start_q;
    logic [7:0]       timer_q;
    logic             tmo_q;
    logic [CW-1:0]    fifo_cnt;
    logic [RES_W-1:0] head;
    logic             accept;

    // Full is judged on the pre-pop count, so a pop never frees a slot for the same cycle.
    assign cmd_ready_o = (state_q == IDLE) && (fifo_cnt != FULL_CNT);
    assign accept      = cmd_valid_i && cmd_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            on_q    <= '0;
            start_q <= 1'b0;
            timer_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        x_q     <= cmd_x_i;
                        on_q    <= cmd_on_i;
                        start_q <= 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer_q <= '0;
                    tmo_q   <= 1'b0;
                    state_q <= WAIT_ACT;
                end
                WAIT_ACT: begin
                    timer_q <= timer_q + 8'd1;
                    if (active_i) begin
                        state_q <= RUN;
                    end else if (timer_q == TMO_LAST) begin
                        tmo_q   <= 1'b1;
                        state_q <= CAPTURE;
                    end
                end
                RUN: begin
                    timer_q <= timer_q + 8'd1;
                    // A normal finish on the last allowed cycle wins over the abort.
                    if (!active_i) begin
                        state_q <= CAPTURE;
                    end else if (timer_q == TMO_LAST) begin
                        tmo_q   <= 1'b1;
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    job_host_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (state_q == CAPTURE),
        .wdata_i (pack_res(y_i, s_i, b_i, regime_i, tmo_q)),
        .pop_i   (res_ready_i),
        .rdata_o (head),
        .count_o (fifo_cnt)
    );

    assign x_o           = x_q;
    assign on_o          = on_q;
    assign start_o       = start_q;
    assign busy_o        = (state_q != IDLE);
    assign res_valid_o   = (fifo_cnt != '0);
    assign res_y_o       = head[RES_Y_O +: 8];
    assign res_s_o       = head[RES_S_O +: 3];
    assign res_b_o       = head[RES_B_O];
    assign res_regime_o  = head[RES_REG_O +: 2];
    assign res_timeout_o = head[RES_TMO_O];

endmodule

// File: tb/tb_job_host.sv
// Self-checking bench for job_host: a cycle-level model of job timing and the result
// queue is compared every cycle, plus literal latency/order expectations per scenario.
module tb_job_host;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cmd_valid_i, cmd_ready_o;
    logic [7:0] cmd_x_i, x_o, y_i, res_y_o;
    logic [1:0] cmd_on_i, on_o, regime_i, res_regime_o;
    logic       start_o, active_i, b_i, res_valid_o, res_ready_i, res_b_o, res_timeout_o, busy_o;
    logic [2:0] s_i, res_s_o;

    job_host #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_x_i(cmd_x_i), .cmd_on_i(cmd_on_i),
        .x_o(x_o), .on_o(on_o), .start_o(start_o),
        .active_i(active_i), .y_i(y_i), .s_i(s_i), .b_i(b_i), .regime_i(regime_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_y_o(res_y_o), .res_s_o(res_s_o), .res_b_o(res_b_o),
        .res_regime_o(res_regime_o), .res_timeout_o(res_timeout_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // What main presents on y/s/b/regime during cycle c.
    function automatic logic [14:0] rec_at(input int c, input logic t);
        logic [31:0] cv;
        cv = c;
        return {cv[7:0] ^ 8'h5A, cv[3:1], cv[0], cv[5:4], t};
    endfunction

    // Behavioural stand-in for main: active follows start by one cycle for job_len cycles.
    int job_len = 1;
    bit stuck   = 1'b0;
    int rem     = 0;
    initial begin
        active_i = 1'b0; y_i = '0; s_i = '0; b_i = 1'b0; regime_i = '0;
        forever begin
            logic [14:0] r;
            @(posedge clk_i);
            #2;
            r = rec_at(cyc, 1'b0);
            {y_i, s_i, b_i, regime_i} = r[14:1];
            if (rst_i) begin
                rem = 0;
                active_i = 1'b0;
            end else begin
                if (rem > 0) begin
                    active_i = 1'b1;
                    rem--;
                end else begin
                    active_i = stuck;
                end
                if (start_o) rem = job_len;
            end
        end
    end

    // Model: a job accepted in cycle T spends D cycles waiting/running (D = active length + 1,
    // unbounded if active never rises or never falls), so the capture cycle is T+2+min(D,TIMEOUT).
    logic [14:0] m_q[$];
    bit          m_job = 1'b0, m_fresh = 1'b1, m_tmo = 1'b0, chk_en = 1'b0;
    int          m_T = -10, m_C = -10;
    logic [7:0]  m_x = '0;
    logic [1:0]  m_on = '0;
    bit          exp_ready;

    always @(negedge clk_i) begin
        exp_ready = !m_job && (m_q.size() < DEPTH);
        if (chk_en) begin
            check("cmd_ready", cmd_ready_o, exp_ready);
            check("busy", busy_o, m_job);
            check("start", start_o, m_job && (cyc == m_T + 1));
            check("x", x_o, m_x);
            check("on", on_o, m_on);
            check("res_valid", res_valid_o, m_q.size() != 0);
            if (m_q.size() != 0)
                check("res_head", {res_y_o, res_s_o, res_b_o, res_regime_o, res_timeout_o}, m_q[0]);
            else if (m_fresh)
                check("res_zero", {res_y_o, res_s_o, res_b_o, res_regime_o, res_timeout_o}, 0);
        end
        if (rst_i) begin
            m_q.delete();
            m_job = 1'b0; m_fresh = 1'b1; m_x = '0; m_on = '0; m_T = -10; m_C = -10;
            chk_en = 1'b1;
        end else begin
            if (res_ready_i && m_q.size() != 0) void'(m_q.pop_front());
            if (m_job && cyc == m_C) begin
                m_q.push_back(rec_at(m_C, m_tmo));
                m_job = 1'b0;
                m_fresh = 1'b0;
            end
            if (cmd_valid_i && exp_ready) begin
                m_job = 1'b1; m_T = cyc; m_x = cmd_x_i; m_on = cmd_on_i;
                if (stuck || job_len == 0 || job_len + 1 > TIMEOUT) begin
                    m_C = cyc + 2 + TIMEOUT; m_tmo = 1'b1;
                end else begin
                    m_C = cyc + 2 + job_len + 1; m_tmo = 1'b0;
                end
            end
        end
    end

    task automatic send_job(input logic [7:0] xv, input logic [1:0] onv, output int t_acc);
        bit got = 1'b0;
        t_acc = -100;
        @(posedge clk_i); #1;
        cmd_x_i = xv; cmd_on_i = onv; cmd_valid_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (cmd_ready_o) begin t_acc = cyc; got = 1'b1; break; end
        end
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        if (!got) check("accept_wait", 0, 1);
    endtask

    task automatic wait_res(output int c_at);
        c_at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (res_valid_o) begin c_at = cyc; break; end
        end
        if (c_at < 0) check("res_wait", 0, 1);
    endtask

    task automatic drain(output int n);
        n = 0;
        @(posedge clk_i); #1;
        res_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (res_valid_o) n++;
            else break;
        end
        @(posedge clk_i); #1;
        res_ready_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ta, c, n;
        logic [31:0] tv;
        cmd_valid_i = 1'b0; cmd_x_i = '0; cmd_on_i = '0; res_ready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset in the middle of a long RUN
        job_len = 8;
        send_job(8'h3C, 2'b10, ta);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("t1_busy_before", busy_o, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("t1_start", start_o, 0);
        check("t1_busy", busy_o, 0);
        check("t1_res_valid", res_valid_o, 0);
        check("t1_x", x_o, 0);

        // Single job, active for 2 cycles
        job_len = 2;
        send_job(8'hA5, 2'b01, ta);
        @(negedge clk_i);
        check("t2_start", start_o, 1);
        check("t2_x", x_o, 8'hA5);
        check("t2_on", on_o, 2'b01);
        wait_res(c);
        check("t2_latency", c - ta, 6);
        check("t2_timeout", res_timeout_o, 0);
        tv = ta + 5;
        check("t2_res_y", res_y_o, tv[7:0] ^ 8'h5A);
        drain(n);
        check("t2_drain", n, 1);

        // Five back-to-back jobs into a 4-deep FIFO
        job_len = 1;
        for (int k = 0; k < 4; k++) send_job(8'h10 + 8'(k), 2'(k), ta);
        repeat (6) @(posedge clk_i);
        @(negedge clk_i);
        check("t3_full_ready", cmd_ready_o, 0);
        @(posedge clk_i); #1;
        cmd_x_i = 8'h14; cmd_on_i = 2'b00; cmd_valid_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 res_ready_i = 1'b1;
        @(negedge clk_i);
        check("t3_ready_during_pop", cmd_ready_o, 0);
        @(posedge clk_i); #1;
        res_ready_i = 1'b0;
        @(negedge clk_i);
        check("t3_ready_after_pop", cmd_ready_o, 1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        repeat (8) @(posedge clk_i);
        drain(n);
        check("t3_drain", n, 4);

        // Active never rises
        job_len = 0;
        send_job(8'h77, 2'b11, ta);
        wait_res(c);
        check("t4_latency", c - ta, 13);
        check("t4_timeout", res_timeout_o, 1);
        check("t4_idle", busy_o, 0);
        drain(n);
        check("t4_drain", n, 1);

        // Active stuck high
        stuck = 1'b1;
        send_job(8'h99, 2'b00, ta);
        wait_res(c);
        check("t5_latency", c - ta, 13);
        check("t5_timeout", res_timeout_o, 1);
        check("t5_idle", busy_o, 0);
        @(posedge clk_i); #1;
        stuck = 1'b0;
        drain(n);
        check("t5_drain", n, 1);

        // Simultaneous push and pop at count DEPTH-1
        job_len = 1;
        for (int k = 0; k < 3; k++) send_job(8'h20 + 8'(k), 2'b10, ta);
        send_job(8'h23, 2'b11, ta);
        for (int i = 0; i < 20; i++) begin
            if (cyc == m_C) break;
            @(posedge clk_i); #1;
        end
        res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        res_ready_i = 1'b0;
        @(negedge clk_i);
        check("t6_valid", res_valid_o, 1);
        drain(n);
        check("t6_drain", n, 3);

        repeat (3) @(posedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
